// File: rtl/nco_multi.sv
// nco_multi: several independent phase accumulators sharing one writable
// waveform table. Each channel has its own increment, phase offset,
// direction and wrap pulse. A single config port programs one channel per
// cycle, and a byte-masked write port loads the table.
module nco_multi #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 16,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int CH_W     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          enable,
  input  logic [CHANNELS-1:0]          updn,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [1:0]                   cfg_sel,
  input  logic [ACC_W-1:0]             cfg_data,
  input  logic                         csb0,
  input  logic                         web0,
  input  logic [DATA_W/8-1:0]          wmask0,
  input  logic [ADDR_W-1:0]            addr0,
  input  logic [DATA_W-1:0]            din0,
  output logic [CHANNELS*ACC_W-1:0]    cout,
  output logic [CHANNELS*DATA_W-1:0]   sine_out,
  output logic [CHANNELS-1:0]          wrap
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int BYTES = DATA_W / 8;

  localparam logic [1:0] SEL_INCR    = 2'd0;
  localparam logic [1:0] SEL_OFFSET  = 2'd1;
  localparam logic [1:0] SEL_PRELOAD = 2'd2;

  // Shared waveform table; deliberately has no reset so contents survive it.
  logic [DATA_W-1:0] table_mem [DEPTH];

  // A write happens only when both active-low strobes are asserted.
  logic table_write;
  assign table_write = !csb0 && !web0;

  // Byte-masked table write; reads elsewhere see the old word this cycle.
  always_ff @(posedge clk) begin
    if (table_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wmask0[b]) begin
          table_mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [CH_W-1:0] MY_CH = CH_W'(k);

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_nxt;
    logic [ACC_W-1:0]  incr_q;
    logic [ADDR_W-1:0] offset_q;
    logic              wrap_q;
    logic              wrap_nxt;
    logic [DATA_W-1:0] sine_q;
    logic              hit;
    logic [ACC_W:0]    up_sum;
    logic [ACC_W:0]    dn_diff;
    logic [ADDR_W-1:0] lookup_addr;

    // Out-of-range channel numbers never match any channel, so they are dropped.
    assign hit = cfg_we && (cfg_ch == MY_CH);

    // The extra top bit carries out on add and goes high on borrow when subtracting.
    assign up_sum  = {1'b0, acc_q} + {1'b0, incr_q};
    assign dn_diff = {1'b0, acc_q} - {1'b0, incr_q};

    // Only the top ADDR_W bits of phase and offset matter for the lookup.
    assign lookup_addr = acc_q[ACC_W-1 -: ADDR_W] + offset_q;

    // Next accumulator value: preload wins over counting, otherwise hold.
    always_comb begin
      acc_nxt  = acc_q;
      wrap_nxt = 1'b0;
      if (hit && (cfg_sel == SEL_PRELOAD)) begin
        acc_nxt  = cfg_data;
        wrap_nxt = 1'b0;
      end else if (enable[k]) begin
        if (updn[k]) begin
          {wrap_nxt, acc_nxt} = up_sum;
        end else begin
          {wrap_nxt, acc_nxt} = dn_diff;
        end
      end
    end

    // Accumulator and its one-cycle wrap pulse.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc_q  <= '0;
        wrap_q <= 1'b0;
      end else begin
        acc_q  <= acc_nxt;
        wrap_q <= wrap_nxt;
      end
    end

    // Increment and offset registers; a count in the write cycle uses the old value.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        incr_q   <= ACC_W'(1);
        offset_q <= '0;
      end else if (hit) begin
        if (cfg_sel == SEL_INCR) begin
          incr_q <= cfg_data;
        end
        if (cfg_sel == SEL_OFFSET) begin
          offset_q <= cfg_data[ACC_W-1 -: ADDR_W];
        end
      end
    end

    // Registered table lookup, trailing the accumulator by one cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sine_q <= '0;
      end else begin
        sine_q <= table_mem[lookup_addr];
      end
    end

    assign cout[k*ACC_W +: ACC_W]      = acc_q;
    assign sine_out[k*DATA_W +: DATA_W] = sine_q;
    assign wrap[k]                      = wrap_q;
  end

endmodule

// File: tb/tb_nco_multi.sv
// tb_nco_multi: self-checking bench for nco_multi with a behavioural model,
// an expected-value queue, a vector table and hand-written corner sequences.
module tb_nco_multi;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   enable;
  logic [3:0]   updn;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [1:0]   cfg_sel;
  logic [15:0]  cfg_data;
  logic         csb0;
  logic         web0;
  logic [3:0]   wmask0;
  logic [7:0]   addr0;
  logic [31:0]  din0;
  logic [63:0]  cout;
  logic [127:0] sine_out;
  logic [3:0]   wrap;

  nco_multi dut (
    .clk(clk), .reset(reset), .enable(enable), .updn(updn),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .cout(cout), .sine_out(sine_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]  cout;
    logic [127:0] sine;
    logic [3:0]   wrap;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic [1:0]  sel;
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  ud;
    int          k;
    logic [15:0] exp_cout;
    logic        exp_wrap;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[11];
  int          tests = 0;
  int          fails = 0;
  logic        chk_sine;

  logic [15:0] m_acc [4];
  logic [15:0] m_incr[4];
  logic [15:0] m_off [4];
  logic [31:0] m_sine[4];
  logic [3:0]  m_wrap;
  logic [31:0] tbl   [256];

  function automatic logic [31:0] word_of(int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, b ^ 8'hA5, ~b, b + 8'h3C};
  endfunction

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_acc[k]  = 16'h0000;
      m_incr[k] = 16'h0001;
      m_off[k]  = 16'h0000;
      m_sine[k] = 32'h0;
    end
    m_wrap = 4'h0;
  endtask

  // One clock: advance the model on the driven inputs, queue the expectation,
  // then compare after the edge.
  task automatic step();
    exp_t        e;
    exp_t        got;
    logic [16:0] t;
    logic [7:0]  a;
    if (!reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        a = m_acc[k][15:8] + m_off[k][15:8];
        m_sine[k] = tbl[a];
        if (cfg_we && cfg_sel == 2'd2 && cfg_ch == 2'(k)) begin
          m_acc[k]  = cfg_data;
          m_wrap[k] = 1'b0;
        end else if (enable[k]) begin
          if (updn[k]) begin
            t = {1'b0, m_acc[k]} + {1'b0, m_incr[k]};
            m_wrap[k] = t[16];
            m_acc[k]  = t[15:0];
          end else begin
            m_wrap[k] = (m_acc[k] < m_incr[k]);
            m_acc[k]  = m_acc[k] - m_incr[k];
          end
        end else begin
          m_wrap[k] = 1'b0;
        end
        if (cfg_we && cfg_ch == 2'(k) && cfg_sel == 2'd0) m_incr[k] = cfg_data;
        if (cfg_we && cfg_ch == 2'(k) && cfg_sel == 2'd1) m_off[k]  = cfg_data;
      end
      if (!csb0 && !web0) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask0[b]) tbl[addr0][b*8 +: 8] = din0[b*8 +: 8];
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      e.cout[k*16 +: 16] = m_acc[k];
      e.sine[k*32 +: 32] = m_sine[k];
    end
    e.wrap = m_wrap;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check("sb_cout", cout, got.cout);
    check("sb_wrap", wrap, got.wrap);
    if (chk_sine) check("sb_sine", sine_out, got.sine);
  endtask

  task automatic cfg_write(logic [1:0] ch, logic [1:0] sel, logic [15:0] data);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic tbl_write(logic [7:0] a, logic [31:0] d, logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    step();
    csb0 = 1'b1; web0 = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    int wraps;
    vecs[0]  = '{1'b1, 2'd2, 2'd2, 16'h0005, 4'h0, 4'hF, 2, 16'h0005, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 4'h4, 4'hF, 2, 16'h0006, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 2'd2, 16'hFFFF, 4'h4, 4'hF, 2, 16'hFFFF, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 4'h4, 4'hF, 2, 16'h0000, 1'b1};
    vecs[4]  = '{1'b1, 2'd1, 2'd0, 16'h0003, 4'h0, 4'hF, 1, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 4'h2, 4'h0, 1, 16'hFFFD, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 4'h0, 4'h0, 1, 16'hFFFD, 1'b0};
    vecs[7]  = '{1'b1, 2'd1, 2'd3, 16'h1234, 4'h2, 4'h0, 1, 16'hFFFA, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 2'd0, 16'h0000, 4'h2, 4'h0, 1, 16'hFFF7, 1'b0};
    vecs[9]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 4'h2, 4'h0, 1, 16'hFFF7, 1'b0};
    vecs[10] = '{1'b1, 2'd1, 2'd1, 16'h8000, 4'h0, 4'h0, 1, 16'hFFF7, 1'b0};

    reset = 1'b0; enable = 4'h0; updn = 4'hF;
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_sel = 2'd0; cfg_data = 16'h0;
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 8'h0; din0 = 32'h0;
    chk_sine = 1'b0;
    for (int i = 0; i < 256; i++) tbl[i] = 32'h0;
    model_reset();
    #2;
    check("reset_cout", cout, 64'h0);
    check("reset_sine", sine_out, 128'h0);
    check("reset_wrap", wrap, 4'h0);
    do_reset();

    // Load the table with a known pattern.
    for (int i = 0; i < 256; i++) tbl_write(8'(i), word_of(i), 4'hF);
    chk_sine = 1'b1;

    // Basic counting after reset; table survives reset.
    do_reset();
    enable = 4'hF; updn = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("t1_cout0", cout[15:0], 16'(i));
      check("t1_cout3", cout[63:48], 16'(i));
      if (i >= 2) check("t1_sine0", sine_out[31:0], word_of(0));
    end

    // Table-driven config/count vectors from a clean reset.
    enable = 4'h0;
    do_reset();
    for (int v = 0; v < 11; v++) begin
      cfg_we = vecs[v].we; cfg_ch = vecs[v].ch; cfg_sel = vecs[v].sel;
      cfg_data = vecs[v].data; enable = vecs[v].en; updn = vecs[v].ud;
      step();
      cfg_we = 1'b0;
      check($sformatf("vec%0d_cout", v), cout[vecs[v].k*16 +: 16], vecs[v].exp_cout);
      check($sformatf("vec%0d_wrap", v), wrap[vecs[v].k], vecs[v].exp_wrap);
    end

    // Disabled channel stays frozen for 10 clocks.
    enable = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("freeze_cout1", cout[31:16], 16'hFFF7);
      check("freeze_wrap1", wrap[1], 1'b0);
    end

    // Coarse increment: one table step per clock, wrap every 256 clocks.
    cfg_write(2'd0, 2'd0, 16'h0100);
    cfg_write(2'd0, 2'd2, 16'h0000);
    enable = 4'h1; updn = 4'hF;
    wraps = 0;
    for (int i = 1; i <= 512; i++) begin
      step();
      if (i == 1) check("t2_first", cout[15:0], 16'h0100);
      if (wrap[0]) begin
        wraps++;
        check("t2_wrap_at_zero", cout[15:0], 16'h0000);
        check("t2_wrap_cycle", 32'(i % 256), 32'd0);
      end
    end
    check("t2_wrap_count", 32'(wraps), 32'd2);

    // Read-before-write and byte masking at address 0x10.
    enable = 4'h0;
    cfg_write(2'd0, 2'd1, 16'h0000);
    tbl_write(8'h10, 32'h11223344, 4'hF);
    cfg_write(2'd0, 2'd2, 16'h1000);
    step();
    check("t5_before", sine_out[31:0], 32'h11223344);
    tbl_write(8'h10, 32'hDEADBEEF, 4'h3);
    check("t5_same_cycle", sine_out[31:0], 32'h11223344);
    step();
    check("t5_after", sine_out[31:0], 32'h1122BEEF);
    csb0 = 1'b1; web0 = 1'b0; addr0 = 8'h10; din0 = 32'h0; wmask0 = 4'hF;
    step();
    csb0 = 1'b0; web0 = 1'b1;
    step();
    csb0 = 1'b1; web0 = 1'b1;
    step();
    check("t5_no_write", sine_out[31:0], 32'h1122BEEF);

    // Quarter-turn offset gives the cosine lookup, including address wrap.
    cfg_write(2'd3, 2'd1, 16'h4000);
    cfg_write(2'd0, 2'd2, 16'h2300);
    cfg_write(2'd3, 2'd2, 16'h2300);
    step();
    check("t6_sine0", sine_out[31:0], word_of(8'h23));
    check("t6_cos3", sine_out[127:96], word_of(8'h63));
    cfg_write(2'd0, 2'd2, 16'hF000);
    cfg_write(2'd3, 2'd2, 16'hF000);
    step();
    check("t6_cos3_wrap", sine_out[127:96], word_of(8'h30));

    // Asynchronous reset in the middle of counting.
    enable = 4'hF; updn = 4'hF;
    step();
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_cout", cout, 64'h0);
    check("t6_async_sine", sine_out, 128'h0);
    check("t6_async_wrap", wrap, 4'h0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("t6_restart", cout[15:0], 16'h0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
